// File: rtl/oh_pads_cfg_pkg.sv
// -----------------------------------------------------------------------------
// oh_pads_cfg_pkg
// Shared types and sizing helpers for the pad-ring configuration chain.
//   state_t    : controller states (IDLE, SHIFT, UPDATE, DONE)
//   chainLen   : total number of serial bits on the chain (pads * bits per pad)
//   bitCntW    : width of a counter that must hold 0..len without wrapping
// -----------------------------------------------------------------------------
package oh_pads_cfg_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SHIFT  = 2'd1,
      UPDATE = 2'd2,
      DONE   = 2'd3
   } state_t;

   // Number of flops in the whole daisy chain
   function automatic int chainLen(input int npads, input int cfgw);
      return npads * cfgw;
   endfunction

   // Bit counter must be able to represent the full length without wrap
   function automatic int bitCntW(input int len);
      return $clog2(len + 1);
   endfunction

endpackage

// File: rtl/oh_pads_cfg_div.sv
// -----------------------------------------------------------------------------
// oh_pads_cfg_div
// Shift strobe generator. While enabled, counts 0..DIV-1 and raises the strobe
// on the last count of every window, so a strobe appears once every DIV cycles
// and the first one lands DIV cycles after enable goes high from a cleared
// count. With DIV=1 the strobe simply follows enable.
// Ports:
//   clk      : core clock
//   nreset   : asynchronous active-low reset
//   i_en     : count enable (high while the controller is shifting)
//   i_clr    : synchronous clear of the window counter
//   o_strobe : one-cycle strobe at the end of each DIV window
// -----------------------------------------------------------------------------
module oh_pads_cfg_div #(
   parameter int DIV = 4
) (
   input  logic clk,
   input  logic nreset,
   input  logic i_en,
   input  logic i_clr,
   output logic o_strobe
);

   localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [CW-1:0] LAST = CW'(DIV - 1);

   logic [CW-1:0] r_cnt;
   logic          w_atLast;

   assign w_atLast = (r_cnt == LAST);
   assign o_strobe = i_en && w_atLast;

   // Window counter: wraps back to zero right after the strobe so the next
   // bit gets a full DIV-cycle window of its own.
   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
         r_cnt <= '0;
      end else if (i_clr) begin
         r_cnt <= '0;
      end else if (i_en) begin
         r_cnt <= w_atLast ? '0 : r_cnt + CW'(1);
      end
   end

endmodule

// File: rtl/oh_pads_cfgchain.sv
// -----------------------------------------------------------------------------
// oh_pads_cfgchain
// Pad-ring configuration chain controller. The host fills a shadow buffer with
// one config word per pad; on go the buffer is shifted serially down the pad
// daisy chain (pad NPADS-1 MSB first, pad 0 LSB last), the bits falling out of
// the chain tail are captured into a readback buffer in the same slots, and a
// single update strobe then makes the pads latch their new config.
// Ports:
//   clk, nreset            : core clock, asynchronous active-low reset
//   wr_valid/wr_ready      : host write handshake (ready only when idle/done)
//   wr_addr, wr_data       : pad index and config word to store
//   rd_addr, rd_data       : combinational readback of captured previous config
//   go                     : start a shift (sampled only when idle/done)
//   busy, done             : busy during SHIFT/UPDATE; done held until go/write
//   chain_out              : registered serial data into the chain head
//   chain_shift            : one-cycle shift strobe to all pad config flops
//   chain_in               : serial data from chain tail, sampled on chain_shift
//   chain_update           : one-cycle latch strobe to all pads
// -----------------------------------------------------------------------------
module oh_pads_cfgchain
   import oh_pads_cfg_pkg::*;
#(
   parameter int NPADS = 16,
   parameter int CFGW  = 8,
   parameter int DIV   = 4
) (
   input  logic                     clk,
   input  logic                     nreset,
   input  logic                     wr_valid,
   output logic                     wr_ready,
   input  logic [$clog2(NPADS)-1:0] wr_addr,
   input  logic [CFGW-1:0]          wr_data,
   input  logic [$clog2(NPADS)-1:0] rd_addr,
   output logic [CFGW-1:0]          rd_data,
   input  logic                     go,
   output logic                     busy,
   output logic                     done,
   output logic                     chain_out,
   output logic                     chain_shift,
   input  logic                     chain_in,
   output logic                     chain_update
);

   localparam int L   = chainLen(NPADS, CFGW);
   localparam int BCW = bitCntW(L);
   localparam int IW  = $clog2(L);
   localparam int AW  = $clog2(NPADS);
   localparam logic [BCW-1:0] LAST_K   = BCW'(L - 1);
   localparam logic [AW-1:0]  HEAD_PAD = AW'(NPADS - 1);

   state_t         r_state;
   state_t         w_nextState;
   logic [L-1:0]   r_shadow;
   logic [L-1:0]   r_readback;
   logic [BCW-1:0] r_bitCnt;
   logic           r_chainOut;

   logic           w_strobe;
   logic           w_lastBit;
   logic           w_wrFire;
   logic           w_goFire;
   logic           w_firstBit;
   logic [IW-1:0]  w_slot;
   logic [IW-1:0]  w_wrBase;
   logic [IW-1:0]  w_rdBase;

   // Both buffers are flattened so that transmit index k lives at flat bit
   // L-1-k: pad NPADS-1 occupies the top CFGW bits, pad 0 the bottom.
   assign w_slot    = IW'(LAST_K - r_bitCnt);
   assign w_wrBase  = IW'(int'(wr_addr) * CFGW);
   assign w_rdBase  = IW'(int'(rd_addr) * CFGW);
   assign w_lastBit = (r_bitCnt == LAST_K);
   assign w_wrFire  = wr_valid && wr_ready;
   assign w_goFire  = go && wr_ready;

   // A write accepted in the same cycle as go must already be visible in the
   // very first bit, so bypass the shadow when the head pad is being written.
   assign w_firstBit = (w_wrFire && (wr_addr == HEAD_PAD)) ? wr_data[CFGW-1]
                                                           : r_shadow[L-1];

   assign rd_data     = r_readback[w_rdBase +: CFGW];
   assign chain_out   = r_chainOut;
   assign chain_shift = w_strobe;

   oh_pads_cfg_div #(
      .DIV (DIV)
   ) u_div (
      .clk      (clk),
      .nreset   (nreset),
      .i_en     (r_state == SHIFT),
      .i_clr    (w_goFire),
      .o_strobe (w_strobe)
   );

   // State register; reset drops straight back to IDLE so an interrupted
   // shift never produces an update strobe.
   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_nextState;
      end
   end

   // Next-state and control outputs. DONE behaves exactly like IDLE except
   // that it reports done; any write or go leaves it.
   always_comb begin
      w_nextState  = r_state;
      wr_ready     = 1'b0;
      busy         = 1'b0;
      done         = 1'b0;
      chain_update = 1'b0;
      case (r_state)
         IDLE: begin
            wr_ready = 1'b1;
            if (go) begin
               w_nextState = SHIFT;
            end
         end
         SHIFT: begin
            busy = 1'b1;
            if (w_strobe && w_lastBit) begin
               w_nextState = UPDATE;
            end
         end
         UPDATE: begin
            busy         = 1'b1;
            chain_update = 1'b1;
            w_nextState  = DONE;
         end
         DONE: begin
            wr_ready = 1'b1;
            done     = 1'b1;
            if (go) begin
               w_nextState = SHIFT;
            end else if (wr_valid) begin
               w_nextState = IDLE;
            end
         end
         default: begin
            w_nextState = IDLE;
         end
      endcase
   end

   // Datapath: host writes into the shadow, then on each strobe capture the
   // returning bit into its slot and present the next bit for a full window.
   // chain_out returns to 0 after the last bit so the head idles low.
   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
         r_shadow   <= '0;
         r_readback <= '0;
         r_bitCnt   <= '0;
         r_chainOut <= 1'b0;
      end else begin
         if (w_wrFire) begin
            r_shadow[w_wrBase +: CFGW] <= wr_data;
         end
         if (w_goFire) begin
            r_bitCnt   <= '0;
            r_chainOut <= w_firstBit;
         end else if (w_strobe) begin
            r_readback[w_slot] <= chain_in;
            r_bitCnt           <= r_bitCnt + BCW'(1);
            r_chainOut         <= w_lastBit ? 1'b0 : r_shadow[w_slot - IW'(1)];
         end
      end
   end

endmodule

// File: tb/tb_oh_pads_cfgchain.sv
// -----------------------------------------------------------------------------
// tb_oh_pads_cfgchain
// Directed bench for the pad configuration chain. Two instances share the
// host write/read bus and reset: instance A runs with DIV=1 and instance B
// with DIV=3, each with its own go and its own pad-chain model (a 32-bit
// shift register clocked by chain_shift, latched by chain_update).
// -----------------------------------------------------------------------------
module tb_oh_pads_cfgchain;

   localparam int NP = 4;
   localparam int CW = 8;

   logic       clk = 1'b0;
   logic       nreset = 1'b1;
   logic       wrValid = 1'b0;
   logic [1:0] wrAddr = '0;
   logic [7:0] wrData = '0;
   logic [1:0] rdAddr = '0;
   logic       goA = 1'b0;
   logic       goB = 1'b0;

   logic       readyA, busyA, doneA, outA, shiftA, inA, updA;
   logic       readyB, busyB, doneB, outB, shiftB, inB, updB;
   logic [7:0] rdA, rdB;

   logic [31:0] chainA = '0;
   logic [31:0] latchA = '0;
   logic [31:0] chainB = '0;
   logic [31:0] latchB = '0;

   int testsRun = 0;
   int testsFailed = 0;

   always #5 clk = ~clk;

   oh_pads_cfgchain #(.NPADS(NP), .CFGW(CW), .DIV(1)) dutA (
      .clk (clk), .nreset (nreset),
      .wr_valid (wrValid), .wr_ready (readyA), .wr_addr (wrAddr), .wr_data (wrData),
      .rd_addr (rdAddr), .rd_data (rdA), .go (goA), .busy (busyA), .done (doneA),
      .chain_out (outA), .chain_shift (shiftA), .chain_in (inA), .chain_update (updA)
   );

   oh_pads_cfgchain #(.NPADS(NP), .CFGW(CW), .DIV(3)) dutB (
      .clk (clk), .nreset (nreset),
      .wr_valid (wrValid), .wr_ready (readyB), .wr_addr (wrAddr), .wr_data (wrData),
      .rd_addr (rdAddr), .rd_data (rdB), .go (goB), .busy (busyB), .done (doneB),
      .chain_out (outB), .chain_shift (shiftB), .chain_in (inB), .chain_update (updB)
   );

   // Pad-ring models: head enters at bit 0, tail is bit 31; after 32 shifts
   // the register reads {pad3, pad2, pad1, pad0}.
   assign inA = chainA[31];
   assign inB = chainB[31];

   always @(posedge clk) begin
      if (shiftA) chainA <= {chainA[30:0], outA};
      if (updA)   latchA <= chainA;
      if (shiftB) chainB <= {chainB[30:0], outB};
      if (updB)   latchB <= chainB;
   end

   // Single comparison point for the whole bench
   task automatic checkOutput(input string tag, input logic [31:0] actual,
                              input logic [31:0] expected);
      testsRun++;
      if (actual !== expected) begin
         testsFailed++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
      end
   endtask

   // Host write of one config word; entered and left just after a rising edge
   task automatic applyStimulus(input logic [1:0] addr, input logic [7:0] data);
      wrValid = 1'b1;
      wrAddr  = addr;
      wrData  = data;
      @(posedge clk); #1;
      wrValid = 1'b0;
   endtask

   // Pulse go on one instance and watch it until done (bounded). Cycle n is
   // the n-th cycle after the go-sampling edge. Optionally injects go plus a
   // write at cycle injAt. Any wrValid preset by the caller rides with go.
   task automatic runGo(input bit useB, input int maxCyc, input int injAt,
                        output int nStrobe, output int firstStrobe,
                        output int updCyc, output int nUpd, output int doneCyc,
                        output int minGap, output int maxGap,
                        output bit outStable, output bit injReadyLow);
      int  lastStrobe;
      bit  prevOut;
      bit  prevStrobe;
      bit  sShift, sUpd, sDone, sOut, sReady;
      nStrobe = 0; firstStrobe = -1; updCyc = -1; nUpd = 0; doneCyc = -1;
      minGap = 1000; maxGap = 0; outStable = 1'b1; injReadyLow = 1'b1;
      lastStrobe = -1; prevOut = 1'b0; prevStrobe = 1'b1;
      if (useB) goB = 1'b1; else goA = 1'b1;
      @(posedge clk); #1;
      goA = 1'b0; goB = 1'b0; wrValid = 1'b0;
      for (int n = 1; n <= maxCyc && doneCyc < 0; n++) begin
         if (n == injAt) begin
            if (useB) goB = 1'b1; else goA = 1'b1;
            wrValid = 1'b1; wrAddr = 2'd0; wrData = 8'h77;
         end
         @(negedge clk);
         sShift = useB ? shiftB : shiftA;
         sUpd   = useB ? updB   : updA;
         sDone  = useB ? doneB  : doneA;
         sOut   = useB ? outB   : outA;
         sReady = useB ? readyB : readyA;
         if (n == injAt && sReady) injReadyLow = 1'b0;
         if (!prevStrobe && sOut !== prevOut) outStable = 1'b0;
         if (sShift) begin
            nStrobe++;
            if (firstStrobe < 0) firstStrobe = n;
            if (lastStrobe >= 0) begin
               if (n - lastStrobe < minGap) minGap = n - lastStrobe;
               if (n - lastStrobe > maxGap) maxGap = n - lastStrobe;
            end
            lastStrobe = n;
         end
         if (sUpd) begin
            nUpd++;
            if (updCyc < 0) updCyc = n;
         end
         if (sDone) doneCyc = n;
         prevOut = sOut;
         prevStrobe = sShift;
         @(posedge clk); #1;
         if (n == injAt) begin
            goA = 1'b0; goB = 1'b0; wrValid = 1'b0;
         end
      end
   endtask

   int  nStrobe, firstStrobe, updCyc, nUpd, doneCyc, minGap, maxGap;
   bit  outStable, injReadyLow;
   int  cnt;
   int  updBefore;

   // Count of update strobes seen on instance A across the whole run
   int  updTotalA = 0;
   always @(posedge clk) if (updA) updTotalA++;

   initial begin
      logic [7:0] expRd [4];

      // 1: reset asserted mid-cycle takes effect immediately
      #12 nreset = 1'b0;
      #1;
      checkOutput("rst wr_ready", readyA, 1);
      checkOutput("rst busy", busyA, 0);
      checkOutput("rst done", doneA, 0);
      checkOutput("rst chain_out", outA, 0);
      checkOutput("rst chain_shift", shiftA, 0);
      checkOutput("rst chain_update", updA, 0);
      rdAddr = 2'd2; #1;
      checkOutput("rst rd_data", rdA, 0);
      checkOutput("rst B wr_ready", readyB, 1);
      @(posedge clk); #1;
      @(posedge clk); #1;
      nreset = 1'b1;
      @(posedge clk); #1;

      // 2: DIV=1 run, words land in their own pads
      applyStimulus(2'd0, 8'hA5);
      applyStimulus(2'd1, 8'h3C);
      applyStimulus(2'd2, 8'hFF);
      applyStimulus(2'd3, 8'h01);
      runGo(1'b0, 60, 0, nStrobe, firstStrobe, updCyc, nUpd, doneCyc,
            minGap, maxGap, outStable, injReadyLow);
      checkOutput("run1 strobes", nStrobe, 32);
      checkOutput("run1 first strobe", firstStrobe, 1);
      checkOutput("run1 update cycle", updCyc, 33);
      checkOutput("run1 update count", nUpd, 1);
      checkOutput("run1 done cycle", doneCyc, 34);
      checkOutput("run1 latched", latchA, 32'h01FF3CA5);
      checkOutput("run1 wr_ready in done", readyA, 1);
      rdAddr = 2'd1; #1;
      checkOutput("run1 readback", rdA, 0);

      // 4: DIV=3 on instance B (same shadow words, written above)
      runGo(1'b1, 140, 0, nStrobe, firstStrobe, updCyc, nUpd, doneCyc,
            minGap, maxGap, outStable, injReadyLow);
      checkOutput("div3 strobes", nStrobe, 32);
      checkOutput("div3 first strobe", firstStrobe, 3);
      checkOutput("div3 min gap", minGap, 3);
      checkOutput("div3 max gap", maxGap, 3);
      checkOutput("div3 chain_out stable", outStable, 1);
      checkOutput("div3 update cycle", updCyc, 97);
      checkOutput("div3 done cycle", doneCyc, 98);
      checkOutput("div3 latched", latchB, 32'h01FF3CA5);

      // 3: second run; pad3 written in the same cycle as go
      applyStimulus(2'd0, 8'h11);
      applyStimulus(2'd1, 8'h22);
      applyStimulus(2'd2, 8'h33);
      wrValid = 1'b1; wrAddr = 2'd3; wrData = 8'h44;
      runGo(1'b0, 60, 0, nStrobe, firstStrobe, updCyc, nUpd, doneCyc,
            minGap, maxGap, outStable, injReadyLow);
      checkOutput("run2 done cycle", doneCyc, 34);
      checkOutput("run2 latched", latchA, 32'h44332211);
      expRd = '{8'hA5, 8'h3C, 8'hFF, 8'h01};
      for (int p = 0; p < 4; p++) begin
         rdAddr = 2'(p); #1;
         checkOutput($sformatf("run2 readback pad%0d", p), rdA, 32'(expRd[p]));
      end

      // 5: go and a write while shifting are ignored
      runGo(1'b0, 60, 10, nStrobe, firstStrobe, updCyc, nUpd, doneCyc,
            minGap, maxGap, outStable, injReadyLow);
      checkOutput("busy wr_ready low", injReadyLow, 1);
      checkOutput("busy strobes", nStrobe, 32);
      checkOutput("busy update count", nUpd, 1);
      checkOutput("busy done cycle", doneCyc, 34);
      checkOutput("busy latched", latchA, 32'h44332211);
      rdAddr = 2'd0; #1;
      checkOutput("busy readback pad0", rdA, 32'h11);

      // 6: reset at bit 13 aborts without an update
      updBefore = updTotalA;
      goA = 1'b1;
      @(posedge clk); #1;
      goA = 1'b0;
      cnt = 0;
      for (int n = 1; n <= 13; n++) begin
         @(negedge clk);
         if (shiftA) cnt++;
         if (n < 13) begin
            @(posedge clk); #1;
         end
      end
      checkOutput("abort strobes before reset", cnt, 13);
      nreset = 1'b0;
      #1;
      checkOutput("abort busy", busyA, 0);
      checkOutput("abort chain_shift", shiftA, 0);
      checkOutput("abort wr_ready", readyA, 1);
      repeat (3) @(posedge clk);
      #1 nreset = 1'b1;
      repeat (40) @(posedge clk);
      #1;
      checkOutput("abort no update", updTotalA - updBefore, 0);
      checkOutput("abort latched kept", latchA, 32'h44332211);
      checkOutput("abort done", doneA, 0);

      // Shadow was cleared by reset, so the next run latches all zeros
      runGo(1'b0, 60, 0, nStrobe, firstStrobe, updCyc, nUpd, doneCyc,
            minGap, maxGap, outStable, injReadyLow);
      checkOutput("after abort done cycle", doneCyc, 34);
      checkOutput("after abort update count", nUpd, 1);
      checkOutput("after abort latched", latchA, 32'h0);

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
